mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single DRAM controller user port between three requesters: VGA scan-out fetch,
//  CPU main-memory access, and MMC disk DMA. VGA has fixed top priority (real-time); CPU and
//  disk alternate round-robin. One transaction is outstanding at a time. A watchdog aborts a
//  transaction the DRAM side never acknowledges.
// PARAMETERS
//  ADDR_W   22   word address width, all ports
//  DATA_W   32   data width, all ports
//  TIMEOUT  1024 cycles in BUSY without mem_ack before abort (>=2)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high
//  vga_req      in   1       VGA read request (vga is read-only)
//  vga_addr     in   ADDR_W  VGA word address
//  vga_ack      out  1       one-cycle completion pulse to VGA
//  cpu_req      in   1       CPU request
//  cpu_we       in   1       CPU 1=write 0=read
//  cpu_addr     in   ADDR_W  CPU word address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_ack      out  1       one-cycle completion pulse to CPU
//  dsk_req      in   1       disk DMA request
//  dsk_we       in   1       disk 1=write 0=read
//  dsk_addr     in   ADDR_W  disk word address
//  dsk_wdata    in   DATA_W  disk write data
//  dsk_ack      out  1       one-cycle completion pulse to disk
//  rdata        out  DATA_W  read data, shared, valid while any *_ack is high
//  mem_req      out  1       request to DRAM controller, held until mem_ack
//  mem_we       out  1       write enable to DRAM controller
//  mem_addr     out  ADDR_W  address to DRAM controller
//  mem_wdata    out  DATA_W  write data to DRAM controller
//  mem_ack      in   1       one-cycle DRAM completion; mem_rdata valid same cycle
//  mem_rdata    in   DATA_W  DRAM read data
//  timeout_err  out  1       sticky: a watchdog abort occurred; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, all *_ack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0,
//   timeout_err=0, rr_next=CPU, wdog=0. Reset mid-transaction drops mem_req at once.
//  Requester rule: hold req/we/addr/wdata stable until own ack; drop req the cycle after ack.
//  States: IDLE, BUSY, ACK (registered FSM, all outputs registered).
//  IDLE: sample reqs. Pick VGA if vga_req; else if cpu_req&dsk_req pick rr_next; else the
//   single requester. On pick: latch grant, mem_we/addr/wdata from winner (vga: we=0,
//   wdata=0), mem_req=1, wdog=0 -> BUSY. No req -> stay IDLE.
//  rr_next toggles to the other of CPU/disk whenever CPU or disk is granted; VGA grants
//   leave it unchanged.
//  BUSY: mem_ack=1 -> mem_req=0, rdata<=mem_rdata, granted ack=1 -> ACK.
//   else wdog+1; wdog==TIMEOUT-1 -> mem_req=0, rdata<=all-ones, granted ack=1,
//   timeout_err=1 -> ACK. mem_ack on the same cycle as expiry counts as success.
//  ACK: ack=0 -> IDLE. Exactly one *_ack pulse per grant.
//  Latency: req sampled in IDLE at cycle 0 -> mem_req high cycle 1; mem_ack at cycle k ->
//   ack at k+1; next grant sampled at k+2 (mem_req k+3).
//  mem_ack outside BUSY is ignored (no ack, no rdata update). mem_addr/we/wdata stay held
//   after mem_req drops until next grant. Request inputs changing mid-BUSY have no effect.
//  Widths: wdog is clog2(TIMEOUT) bits, no wrap (cleared on each grant).
// TESTING
//  1 CPU read 0x000100, DRAM acks 3 cycles after mem_req with 0xDEADBEEF -> cpu_ack one
//    cycle, rdata=0xDEADBEEF, mem_addr=0x000100, mem_we=0.
//  2 cpu_req & dsk_req held continuously, 4 transactions -> grants CPU,DSK,CPU,DSK; no ack
//    to the non-granted side.
//  3 cpu_req, dsk_req, vga_req all high -> VGA granted first each IDLE while vga_req high;
//    CPU/disk order still alternates afterwards.
//  4 disk write 0x12345678 to 0x3FFFFF -> mem_we=1, mem_wdata=0x12345678, mem_addr=0x3FFFFF.
//  5 TIMEOUT=16, DRAM never acks -> mem_req drops after 16 BUSY cycles, ack with
//    rdata=0xFFFFFFFF, timeout_err=1 and stays 1; next request served normally.
//  6 reset asserted during BUSY -> mem_req=0 and no ack issued; stray mem_ack in IDLE -> no
//    ack, rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one DRAM user port between VGA, CPU and disk DMA requesters.
//   VGA has fixed top priority; CPU and disk alternate round-robin. One transaction
//   is outstanding at a time, and a watchdog aborts a transaction that is never acked.
//   Ports: clk, reset (async, active-high); vga_req/addr -> vga_ack;
//   cpu_req/we/addr/wdata -> cpu_ack; dsk_req/we/addr/wdata -> dsk_ack; rdata (shared);
//   mem_req/we/addr/wdata <- mem_ack/mem_rdata; timeout_err (sticky).
module mem_arbiter #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dsk_req,
    input  logic              dsk_we,
    input  logic [ADDR_W-1:0] dsk_addr,
    input  logic [DATA_W-1:0] dsk_wdata,
    output logic              dsk_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    typedef enum logic [1:0] {G_VGA, G_CPU, G_DSK} grant_t;
    state_t state;
    grant_t grant;
    logic rr_dsk;
    logic [WD_W-1:0] wdog;
    logic pick_cpu, pick_dsk;
    // rr_dsk only breaks the tie when CPU and disk both request and VGA is quiet
    assign pick_cpu = !vga_req && cpu_req && (!dsk_req || !rr_dsk);
    assign pick_dsk = !vga_req && dsk_req && !pick_cpu;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= G_VGA;
            rr_dsk      <= 1'b0;
            wdog        <= '0;
            vga_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            dsk_ack     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (vga_req || cpu_req || dsk_req) begin
                    grant     <= vga_req ? G_VGA : pick_cpu ? G_CPU : G_DSK;
                    mem_we    <= pick_cpu ? cpu_we : pick_dsk ? dsk_we : 1'b0;
                    mem_addr  <= vga_req ? vga_addr : pick_cpu ? cpu_addr : dsk_addr;
                    mem_wdata <= pick_cpu ? cpu_wdata : pick_dsk ? dsk_wdata : '0;
                    if (!vga_req) rr_dsk <= pick_cpu;
                    mem_req   <= 1'b1;
                    wdog      <= '0;
                    state     <= BUSY;
                end
                // an ack arriving on the expiry cycle still counts as success
                BUSY: if (mem_ack || wdog == WD_W'(TIMEOUT - 1)) begin
                    mem_req <= 1'b0;
                    rdata   <= mem_ack ? mem_rdata : '1;
                    if (!mem_ack) timeout_err <= 1'b1;
                    vga_ack <= grant == G_VGA;
                    cpu_ack <= grant == G_CPU;
                    dsk_ack <= grant == G_DSK;
                    state   <= ACK;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                default: begin
                    vga_ack <= 1'b0;
                    cpu_ack <= 1'b0;
                    dsk_ack <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
